// File: rtl/clkdiv_sched.sv
// -----------------------------------------------------------------------------
// clkdiv_sched
//
// Runtime-reconfigurable clock divider. NREQ requesters share the divide
// limit. Each asks for a new limit over a level req / pulsed ack handshake.
// A small scheduler picks one request at a time and checks it. A request
// below 2 is rejected (ack + nack). A valid limit is applied only at the end
// of the current divider period, so clk_div never shows a runt pulse.
//
// Configuration macro:
//   CLKDIV_SCHED_RR_EN  defined   : round-robin arbitration starting at rr_ptr
//                       undefined : fixed priority, lowest index wins
//
// Ports:
//   sysclk     in   1           system clock, all logic on rising edge
//   reset      in   1           asynchronous active-high reset
//   req        in   NREQ        per-requester level request
//   limit_in   in   NREQ*WIDTH  requested limits, requester i at [i*WIDTH +: WIDTH]
//   ack        out  NREQ        one-cycle registered completion pulse
//   nack       out  1           registered, high with ack on a rejected request
//   clk_div    out  1           registered divided clock
//   tick       out  1           high in the last cycle of each period
//   cur_limit  out  WIDTH       limit currently in force
//   busy       out  1           scheduler is handling a request
// -----------------------------------------------------------------------------
module clkdiv_sched #(
    parameter int CLOCK_FREQ = 20_000_000,
    parameter int F_OUT      = 17,
    parameter int NREQ       = 2,
    parameter int WIDTH      = 32
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   limit_in,
    output logic [NREQ-1:0]         ack,
    output logic                    nack,
    output logic                    clk_div,
    output logic                    tick,
    output logic [WIDTH-1:0]        cur_limit,
    output logic                    busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(CLOCK_FREQ / F_OUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_PEND  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  counter_q, counter_d;
    logic              clk_div_q, clk_div_d;
    logic [WIDTH-1:0]  cur_limit_q, cur_limit_d;
    logic [WIDTH-1:0]  pend_limit_q, pend_limit_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              nack_q, nack_d;

    logic              tick_s;
    logic [IDXW-1:0]   rr_ptr_s;
    logic [IDXW-1:0]   cand_s;
    logic [IDXW-1:0]   win_idx_s;
    logic              win_found_s;

    // Last cycle of the period; cur_limit is always >= 2 so the subtraction never wraps.
    assign tick_s = (counter_q == (cur_limit_q - WIDTH'(1)));

`ifdef CLKDIV_SCHED_RR_EN
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin pointer moves past the requester just served.
    always_comb begin
        if (state_q == S_ACK) begin
            rr_ptr_d = IDXW'((int'(grant_q) + 1) % NREQ);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr_s = rr_ptr_q;
`else
    // Fixed priority: search always starts at requester 0.
    assign rr_ptr_s = '0;
`endif

    // Arbiter: first set req bit scanning upward from rr_ptr, wrapping around.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDXW'((int'(rr_ptr_s) + k) % NREQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Scheduler FSM and divider next-state.
    always_comb begin
        state_d      = state_q;
        pend_limit_d = pend_limit_q;
        grant_d      = grant_q;
        cur_limit_d  = cur_limit_q;
        ack_d        = '0;
        nack_d       = 1'b0;
        if (tick_s) begin
            counter_d = '0;
        end else begin
            counter_d = counter_q + WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (win_found_s) begin
                    grant_d      = win_idx_s;
                    pend_limit_d = limit_in[int'(win_idx_s)*WIDTH +: WIDTH];
                    state_d      = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // A limit below 2 cannot form a period with both phases.
                if (pend_limit_q < WIDTH'(2)) begin
                    ack_d[grant_q] = 1'b1;
                    nack_d         = 1'b1;
                    state_d        = S_ACK;
                end else begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                // Swap limits only on the period boundary; equal limits are not short-cut.
                if (tick_s) begin
                    cur_limit_d    = pend_limit_q;
                    counter_d      = '0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_ACK;
                end else begin
                    state_d = S_PEND;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Low for floor(L/2) cycles, high for the remainder of the period.
        clk_div_d = (counter_d >= (cur_limit_d >> 1));
    end

    // State, divider and output registers.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            counter_q    <= '0;
            clk_div_q    <= 1'b0;
            cur_limit_q  <= DEFAULT_LIMIT;
            pend_limit_q <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            nack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            clk_div_q    <= clk_div_d;
            cur_limit_q  <= cur_limit_d;
            pend_limit_q <= pend_limit_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
        end
    end

    assign ack       = ack_q;
    assign nack      = nack_q;
    assign clk_div   = clk_div_q;
    assign tick      = tick_s;
    assign cur_limit = cur_limit_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_clkdiv_sched.sv
// -----------------------------------------------------------------------------
// Testbench for clkdiv_sched (CLOCK_FREQ=20, F_OUT=2, NREQ=2, WIDTH=32).
// A transaction-level reference model predicts the period phase, limit in
// force and handshake outputs every cycle; directed steps and random
// requests are compared against it.
// -----------------------------------------------------------------------------
module tb_clkdiv_sched;

    localparam int CF   = 20;
    localparam int FO   = 2;
    localparam int NREQ = 2;
    localparam int W    = 32;

    logic                sysclk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   limit_in;
    logic [NREQ-1:0]     ack;
    logic                nack;
    logic                clk_div;
    logic                tick;
    logic [W-1:0]        cur_limit;
    logic                busy;

    clkdiv_sched #(
        .CLOCK_FREQ (CF),
        .F_OUT      (FO),
        .NREQ       (NREQ),
        .WIDTH      (W)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .req       (req),
        .limit_in  (limit_in),
        .ack       (ack),
        .nack      (nack),
        .clk_div   (clk_div),
        .tick      (tick),
        .cur_limit (cur_limit),
        .busy      (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: limit in force, position inside the period, and the
    // request currently being served.
    longint m_lim;
    longint m_phase;
    longint m_val;
    bit     m_active;
    bit     m_in_ack;
    bit     m_nack;
    int     m_age;
    int     m_who;
    int     m_next;
    int     ack_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lim    = CF / FO;
        m_phase  = 0;
        m_val    = 0;
        m_active = 0;
        m_in_ack = 0;
        m_nack   = 0;
        m_age    = 0;
        m_who    = 0;
        m_next   = 0;
    endtask

    // One rising edge of the model, using the req/limit values seen before it.
    task automatic model_edge(input logic [NREQ-1:0] rq, input logic [NREQ*W-1:0] li);
        bit wrap;
        bit apply;
        int idx;
        wrap  = (m_phase == m_lim - 1);
        apply = 0;
        if (m_active) begin
            if (m_in_ack) begin
                m_active = 0;
                m_in_ack = 0;
`ifdef CLKDIV_SCHED_RR_EN
                m_next = (m_who + 1) % NREQ;
`else
                m_next = 0;
`endif
            end else if (m_age == 0) begin
                m_age = 1;
                if (m_val < 2) begin
                    m_in_ack = 1;
                    m_nack   = 1;
                end
            end else if (wrap) begin
                apply    = 1;
                m_in_ack = 1;
                m_nack   = 0;
            end
        end else if (rq != '0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (m_next + k) % NREQ;
                if (rq[idx]) m_who = idx;
            end
            m_val    = longint'(li[m_who*W +: W]);
            m_active = 1;
            m_age    = 0;
            m_in_ack = 0;
            m_nack   = 0;
        end
        if (apply) begin
            m_lim   = m_val;
            m_phase = 0;
        end else begin
            m_phase = wrap ? 0 : m_phase + 1;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] exp_ack;
        exp_ack = m_in_ack ? NREQ'(1 << m_who) : '0;
        chk("clk_div",   64'(clk_div),   64'(m_phase >= m_lim / 2));
        chk("tick",      64'(tick),      64'(m_phase == m_lim - 1));
        chk("cur_limit", 64'(cur_limit), 64'(m_lim));
        chk("busy",      64'(busy),      64'(m_active));
        chk("ack",       64'(ack),       64'(exp_ack));
        chk("nack",      64'(nack),      64'(m_in_ack && m_nack));
        if (ack != '0) ack_log.push_back(ack[1] ? 1 : 0);
    endtask

    // One clock: requesters drop req on the edge where they see ack.
    task automatic cycle();
        logic [NREQ-1:0]   rq_s;
        logic [NREQ*W-1:0] li_s;
        logic [NREQ-1:0]   ack_s;
        rq_s  = req;
        li_s  = limit_in;
        ack_s = ack;
        @(posedge sysclk);
        model_edge(rq_s, li_s);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_s[i]) req[i] = 1'b0;
        end
        check_outputs();
    endtask

    task automatic raise(input int i, input longint v);
        limit_in[i*W +: W] = W'(v);
        req[i] = 1'b1;
    endtask

    task automatic run_quiet(input int budget);
        int n;
        n = 0;
        while ((req != '0 || m_active) && n < budget) begin
            cycle();
            n++;
        end
        chk("quiesce_req", 64'(req), 64'(0));
    endtask

    task automatic wait_phase(input longint p);
        int n;
        n = 0;
        while (m_phase != p && n < 40) begin
            cycle();
            n++;
        end
    endtask

    // Reset asserted mid-cycle; outputs must return to defaults without a clock.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        req   = '0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_cur_limit", 64'(cur_limit), 64'(10));
        chk("rst_busy",      64'(busy),      64'(0));
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        check_outputs();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] first_ack();
        return (ack_log.size() > 0) ? 64'(ack_log[0]) : 64'hFFFF;
    endfunction

    function automatic logic [63:0] second_ack();
        return (ack_log.size() > 1) ? 64'(ack_log[1]) : 64'hFFFF;
    endfunction

    initial begin
        reset    = 1'b1;
        req      = '0;
        limit_in = '0;
        model_reset();
        repeat (3) @(negedge sysclk);
        check_outputs();
        chk("reset_limit", 64'(cur_limit), 64'(10));
        reset = 1'b0;

        // Default divide-by-10: 5 low / 5 high, tick every 10 cycles.
        repeat (25) cycle();

        // Single change to 4, raised at counter 2.
        wait_phase(2);
        raise(0, 4);
        run_quiet(30);
        repeat (10) cycle();

        // Reject limit 1: ack+nack visible after the second edge.
        raise(1, 1);
        cycle();
        cycle();
        chk("reject_ack_nack", 64'({nack, ack}), 64'(3'b110));
        run_quiet(10);
        repeat (6) cycle();

        // Contention, first pair: requester 0 wins under both policies.
        ack_log.delete();
        raise(0, 6);
        raise(1, 8);
        run_quiet(80);
        chk("pair1_first",  first_ack(),  64'(0));
        chk("pair1_second", second_ack(), 64'(1));

        // Odd limit 5: 2 low / 3 high.
        raise(0, 5);
        run_quiet(40);
        repeat (12) cycle();

        // Contention, second pair.
        ack_log.delete();
        raise(0, 6);
        raise(1, 8);
        run_quiet(80);
`ifdef CLKDIV_SCHED_RR_EN
        chk("pair2_first",  first_ack(),  64'(1));
        chk("pair2_second", second_ack(), 64'(0));
`else
        chk("pair2_first",  first_ack(),  64'(0));
        chk("pair2_second", second_ack(), 64'(1));
`endif

        // Minimum valid limit, then re-apply the same limit.
        raise(1, 2);
        run_quiet(40);
        repeat (6) cycle();
        raise(0, 2);
        run_quiet(20);
        repeat (4) cycle();

        // Full-width limit is accepted and applied.
        raise(0, 64'hFFFF_FFFF);
        run_quiet(20);
        repeat (8) cycle();
        chk("max_limit", 64'(cur_limit), 64'hFFFF_FFFF);
        mid_reset();
        repeat (12) cycle();

        // Reset while a valid request waits for the boundary.
        wait_phase(0);
        raise(0, 7);
        repeat (3) cycle();
        chk("pend_busy", 64'(busy), 64'(1));
        mid_reset();
        repeat (15) cycle();

        // Random requests.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom_range(0, 1) == 1)) raise(i, longint'($urandom_range(0, 12)));
            end
            repeat ($urandom_range(1, 15)) cycle();
        end
        run_quiet(300);
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
